// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: FSM encoding,
// writeback source indices and default register-file widths.
package regfile_wb_arbiter_pkg;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_DBG  = 2;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin priority picker: the first set request at or after
// ptr (wrapping) wins; outputs a one-hot grant, its index and an any-flag.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] req_rot;
    logic [N-1:0] ptr_match;

    // ptr_match[gi] marks the slot the search starts from.
    for (genvar gi = 0; gi < N; gi++) begin : g_ptr
        assign ptr_match[gi] = (ptr == IDX_W'(gi));
        assign req_rot[gi]   = req[gi];
    end

    always_comb begin
        int s;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        s     = 0;
        for (int k = 0; k < N; k++) begin
            s = (int'(ptr) + k) % N;
            if (!any && req_rot[s] && (|ptr_match)) begin
                any      = 1'b1;
                grant[s] = 1'b1;
                idx      = IDX_W'(s);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter with per-source burst lock sharing the register file's
// single write port; the write port is driven from a registered stage.
// Optional: define REGFILE_WB_ARB_X0_DROP_EN to suppress reg_we for writes to x0.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W,
    parameter int DATA_W  = regfile_wb_arbiter_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wd,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        reg_we,
    output logic [ADDR_W-1:0]           rd,
    output logic [DATA_W-1:0]           wd,
    output logic [2:0]                  grant_id,
    output logic                        locked
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic               reg_we_reg;
    logic [ADDR_W-1:0]  rd_reg;
    logic [DATA_W-1:0]  wd_reg;
    logic [2:0]         grant_id_reg;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] ready_next;
    logic [IDX_W-1:0]   win_idx;
    logic               accept;
    logic               write_en;

    logic [ADDR_W-1:0]  rd_arr [NUM_REQ];
    logic [DATA_W-1:0]  wd_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign rd_arr[gi] = req_rd[gi*ADDR_W +: ADDR_W];
        assign wd_arr[gi] = req_wd[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        ready_next = '0;
        win_idx    = owner_reg;
        accept     = 1'b0;
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;

        case (state_reg)
            ST_ARB: begin
                ready_next = pick_grant;
                win_idx    = pick_idx;
                accept     = pick_any;
            end
            ST_LOCKED: begin
                accept              = req_valid[owner_reg];
                ready_next[owner_reg] = accept;
            end
            default: ;
        endcase

        // Grant is withheld during reset so no source believes it was accepted.
        if (reset) begin
            ready_next = '0;
            accept     = 1'b0;
        end

        if (accept) begin
            ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (req_lock[win_idx]) begin
                state_next = ST_LOCKED;
                owner_next = win_idx;
            end else begin
                state_next = ST_ARB;
            end
        end
    end

`ifdef REGFILE_WB_ARB_X0_DROP_EN
    assign write_en = accept && (rd_arr[win_idx] != '0);
`else
    assign write_en = accept;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_ARB;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            reg_we_reg   <= 1'b0;
            rd_reg       <= '0;
            wd_reg       <= '0;
            grant_id_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            reg_we_reg <= write_en;
            // Index/data/id only move on a real write so they hold otherwise.
            if (write_en) begin
                rd_reg       <= rd_arr[win_idx];
                wd_reg       <= wd_arr[win_idx];
                grant_id_reg <= 3'(win_idx);
            end
        end
    end

    assign req_ready = ready_next;
    assign reg_we    = reg_we_reg;
    assign rd        = rd_reg;
    assign wd        = wd_reg;
    assign grant_id  = grant_id_reg;
    assign locked    = (state_reg == ST_LOCKED);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin/lock model.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 8;
`ifdef REGFILE_WB_ARB_X0_DROP_EN
    localparam bit X0_DROP = 1'b1;
`else
    localparam bit X0_DROP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_lock = '0;
    logic [N*AW-1:0]   req_rd = '0;
    logic [N*DW-1:0]   req_wd = '0;
    logic [N-1:0]      req_ready;
    logic              reg_we;
    logic [AW-1:0]     rd;
    logic [DW-1:0]     wd;
    logic [2:0]        grant_id;
    logic              locked;

    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_rd    (req_rd),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .reg_we    (reg_we),
        .rd        (rd),
        .wd        (wd),
        .grant_id  (grant_id),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int            m_ptr = 0;
    bit            m_locked = 1'b0;
    int            m_owner = 0;
    int            m_win = -1;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_rd = '0;
    logic [DW-1:0] m_wd = '0;
    logic [2:0]    m_gid = '0;
    logic [N-1:0]  exp_ready;

    // Observed DUT values
    logic [N-1:0]  obs_ready;
    logic          obs_we;
    logic [AW-1:0] obs_rd;
    logic [DW-1:0] obs_wd;
    logic [2:0]    obs_gid;
    logic          obs_locked;

    task automatic tick(input logic [N-1:0] v, input logic [N-1:0] lk,
                        input logic [N*AW-1:0] rds, input logic [N*DW-1:0] wds,
                        input logic rst);
        logic [N-1:0] one;
        logic [AW-1:0] wrd;
        one = 1;
        @(negedge clk);
        reset = rst; req_valid = v; req_lock = lk; req_rd = rds; req_wd = wds;
        #2;
        obs_ready = req_ready;
        m_win = -1;
        if (!rst) begin
            if (m_locked) begin
                if (v[m_owner]) m_win = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int s;
                    s = (m_ptr + k) % N;
                    if (m_win < 0 && v[s]) m_win = s;
                end
            end
        end
        exp_ready = (m_win >= 0) ? (one << m_win) : '0;
        @(posedge clk);
        #1;
        if (rst) begin
            m_ptr = 0; m_locked = 0; m_owner = 0;
            m_we = 0; m_rd = '0; m_wd = '0; m_gid = '0;
        end else if (m_win >= 0) begin
            m_ptr = (m_win + 1) % N;
            if (lk[m_win]) begin
                m_locked = 1; m_owner = m_win;
            end else begin
                m_locked = 0;
            end
            wrd  = rds[m_win*AW +: AW];
            m_we = !(X0_DROP && wrd == 0);
            if (m_we) begin
                m_rd = wrd; m_wd = wds[m_win*DW +: DW]; m_gid = 3'(m_win);
            end
        end else begin
            m_we = 0;
        end
        obs_we = reg_we; obs_rd = rd; obs_wd = wd; obs_gid = grant_id; obs_locked = locked;
    endtask

    task automatic test_reset();
        tick(3'b111, 3'b000, '0, '0, 1'b1);
        checks++; if (obs_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b expected 000", obs_ready); end
        tick(3'b111, 3'b111, '0, '0, 1'b1);
        checks++; if (obs_we !== 1'b0 || obs_rd !== '0 || obs_wd !== '0 || obs_gid !== '0 || obs_locked !== 1'b0) begin
            errors++; $display("FAIL reset_state got we=%b rd=%0d wd=%h gid=%0d lk=%b expected all zero", obs_we, obs_rd, obs_wd, obs_gid, obs_locked);
        end
        for (int i = 0; i < 5; i++) begin
            tick(3'b000, 3'b000, 15'($urandom), 24'($urandom), 1'b0);
            checks++; if (obs_ready !== 3'b000 || obs_we !== 1'b0 || obs_rd !== '0 || obs_wd !== '0 || obs_locked !== 1'b0) begin
                errors++; $display("FAIL idle[%0d] got rdy=%b we=%b rd=%0d wd=%h lk=%b expected 000/0/0/00/0", i, obs_ready, obs_we, obs_rd, obs_wd, obs_locked);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single_beat();
        tick(3'b010, 3'b000, {5'd0, 5'd7, 5'd0}, {8'h00, 8'h5A, 8'h00}, 1'b0);
        checks++; if (obs_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b expected 010", obs_ready); end
        checks++; if (obs_we !== 1'b1 || obs_rd !== 5'd7 || obs_wd !== 8'h5A || obs_gid !== 3'd1) begin
            errors++; $display("FAIL single_out got we=%b rd=%0d wd=%h gid=%0d expected 1/7/5a/1", obs_we, obs_rd, obs_wd, obs_gid);
        end
        $display("test_single_beat rdy=%b we=%b rd=%0d wd=%h gid=%0d", obs_ready, obs_we, obs_rd, obs_wd, obs_gid);
    endtask

    task automatic test_fairness();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        logic [N-1:0] one;
        one = 1;
        tick(3'b000, 3'b000, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(3'b111, 3'b000, 15'($urandom), 24'($urandom), 1'b0);
            checks++; if (obs_ready !== (one << order[i]) || obs_we !== 1'b1 || obs_gid !== 3'(order[i])) begin
                errors++; $display("FAIL fair[%0d] got rdy=%b we=%b gid=%0d expected grant %0d", i, obs_ready, obs_we, obs_gid, order[i]);
            end
            $display("test_fairness beat %0d rdy=%b gid=%0d", i, obs_ready, obs_gid);
        end
        tick(3'b000, 3'b000, '0, '0, 1'b0);
        checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL fair_tail got we=%b expected 0", obs_we); end
    endtask

    task automatic test_lock_burst();
        logic [N-1:0] lks  [5] = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
        logic [N-1:0] rdys [5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
        logic         lkd  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tick(3'b000, 3'b000, '0, '0, 1'b1);
        tick(3'b010, 3'b000, {5'd0, 5'd3, 5'd0}, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(3'b111, lks[i], {5'd9, 5'd10, 5'd11}, 24'($urandom), 1'b0);
            checks++; if (obs_ready !== rdys[i] || obs_locked !== lkd[i] || obs_we !== 1'b1) begin
                errors++; $display("FAIL lock[%0d] got rdy=%b lk=%b we=%b expected rdy=%b lk=%b we=1", i, obs_ready, obs_locked, obs_we, rdys[i], lkd[i]);
            end
            $display("test_lock_burst beat %0d rdy=%b locked=%b", i, obs_ready, obs_locked);
        end
    endtask

    task automatic test_reset_mid_lock();
        tick(3'b000, 3'b000, '0, '0, 1'b1);
        tick(3'b001, 3'b000, {5'd0, 5'd0, 5'd4}, '0, 1'b0);
        tick(3'b010, 3'b010, {5'd0, 5'd5, 5'd0}, '0, 1'b0);
        checks++; if (obs_locked !== 1'b1) begin errors++; $display("FAIL midlock_enter got lk=%b expected 1", obs_locked); end
        tick(3'b010, 3'b010, {5'd0, 5'd6, 5'd0}, '0, 1'b0);
        tick(3'b111, 3'b111, {5'd1, 5'd2, 5'd3}, '0, 1'b1);
        checks++; if (obs_ready !== 3'b000 || obs_locked !== 1'b0 || obs_we !== 1'b0) begin
            errors++; $display("FAIL midlock_reset got rdy=%b lk=%b we=%b expected 000/0/0", obs_ready, obs_locked, obs_we);
        end
        tick(3'b111, 3'b000, {5'd1, 5'd2, 5'd3}, '0, 1'b0);
        checks++; if (obs_ready !== 3'b001 || obs_gid !== 3'd0) begin
            errors++; $display("FAIL midlock_after got rdy=%b gid=%0d expected 001/0", obs_ready, obs_gid);
        end
        $display("test_reset_mid_lock rdy=%b gid=%0d", obs_ready, obs_gid);
    endtask

    task automatic test_x0_write();
        logic          exp_we;
        logic [DW-1:0] exp_wd;
        exp_we = !X0_DROP;
        exp_wd = X0_DROP ? 8'h00 : 8'hFF;
        tick(3'b000, 3'b000, '0, '0, 1'b1);
        tick(3'b001, 3'b000, {5'd9, 5'd9, 5'd0}, {8'h11, 8'h22, 8'hFF}, 1'b0);
        checks++; if (obs_ready !== 3'b001) begin errors++; $display("FAIL x0_ready got %b expected 001", obs_ready); end
        checks++; if (obs_we !== exp_we || obs_rd !== 5'd0 || obs_wd !== exp_wd) begin
            errors++; $display("FAIL x0_out got we=%b rd=%0d wd=%h expected %b/0/%h", obs_we, obs_rd, obs_wd, exp_we, exp_wd);
        end
        $display("test_x0_write we=%b rd=%0d wd=%h", obs_we, obs_rd, obs_wd);
    endtask

    task automatic test_random();
        logic [N-1:0] v, lk;
        logic         rst;
        for (int i = 0; i < 400; i++) begin
            v   = 3'($urandom);
            lk  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            rst = ($urandom_range(0, 49) == 0);
            tick(v, lk, 15'($urandom), 24'($urandom), rst);
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b expected %b", i, obs_ready, exp_ready); end
            checks++; if (obs_we !== m_we || obs_rd !== m_rd || obs_wd !== m_wd || obs_gid !== m_gid || obs_locked !== m_locked) begin
                errors++; $display("FAIL rand_out[%0d] got we=%b rd=%0d wd=%h gid=%0d lk=%b expected %b/%0d/%h/%0d/%b",
                                   i, obs_we, obs_rd, obs_wd, obs_gid, obs_locked, m_we, m_rd, m_wd, m_gid, m_locked);
            end
            $display("test_random %0d v=%b lk=%b rst=%b rdy=%b we=%b rd=%0d wd=%h gid=%0d", i, v, lk, rst, obs_ready, obs_we, obs_rd, obs_wd, obs_gid);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_fairness();
        test_lock_burst();
        test_reset_mid_lock();
        test_x0_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
